sd_bd_sched: RTL and testbench
==============================

// Module: sd_bd_sched
// PURPOSE
//  Round-robin scheduler between the TX and RX buffer-descriptor (BD) buffers.
//  - Detects pending BDs from each buffer's free_bd count.
//  - Fetches the 2-word BD (system buffer addr, SD block addr) over the buffer's read port.
//  - Launches one transfer on the SD data engine, waits for its completion, then pulses a_cmp.
//  - Sits between the two BD buffers and the data-transfer master; it owns all BD read/retire traffic.
// PARAMETERS
//  RAM_MEM_WIDTH  32  BD word width; 32-bit mode only, 2 words per BD.
//  BD_WIDTH       8   width of free_bd counts.
//  BD_PAIRS       8   free_bd value when a buffer is empty (BD_SIZE/2).
// PORTS
//  clk            in   1              system clock
//  rst_n          in   1              asynchronous reset, active low
//  en             in   1              scheduler enable; sampled only in IDLE
//  free_bd_tx     in   BD_WIDTH       TX buffer free-slot count
//  free_bd_rx     in   BD_WIDTH       RX buffer free-slot count
//  re_tx          out  1              TX BD read strobe; data valid on the next cycle
//  re_rx          out  1              RX BD read strobe; data valid on the next cycle
//  dat_tx         in   RAM_MEM_WIDTH  TX BD read data
//  dat_rx         in   RAM_MEM_WIDTH  RX BD read data
//  a_cmp_tx       out  1              TX BD retire pulse
//  a_cmp_rx       out  1              RX BD retire pulse
//  xfer_start     out  1              1-cycle launch pulse to the data engine
//  xfer_dir       out  1              1 = TX (write to card), 0 = RX
//  xfer_sys_addr  out  RAM_MEM_WIDTH  BD word 0
//  xfer_blk_addr  out  RAM_MEM_WIDTH  BD word 1
//  xfer_done      in   1              engine completion pulse
//  xfer_err       in   1              qualifies xfer_done as failed
//  busy           out  1              high in every state except IDLE
//  err            out  1              sticky transfer-error flag
//  clr_err        in   1              clears err
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; last_grant = RX, so TX wins first.
//  Mid-operation reset aborts any BD in progress. No a_cmp is issued for an aborted BD.
//  pend_x = (free_bd_x < BD_PAIRS), evaluated combinationally.
//  Grant rule:
//    - Both pending: grant the side != last_grant.
//    - One pending: grant that side.
//    - last_grant updates at grant time.
//  FSM:
//    IDLE  -> RD0 when en && (pend_tx || pend_rx). Latch grant.
//    RD0   : re_<g>=1 for one cycle -> CAP0.
//    CAP0  : xfer_sys_addr <= dat_<g>; re_<g>=1 -> CAP1.
//    CAP1  : xfer_blk_addr <= dat_<g> -> LAUNCH.
//    LAUNCH: xfer_start=1 for one cycle; xfer_dir = (g==TX) -> BUSY.
//    BUSY  : wait for xfer_done -> CMPL. If xfer_err is set with it, err <= 1.
//    CMPL  : a_cmp_<g>=1 for exactly one cycle -> HOLD.
//    HOLD  : one dead cycle so the buffer's free_bd update lands before re-arbitration -> IDLE.
//  Timing:
//    - Fixed 1-cycle read latency: word0 is captured in CAP0, word1 in CAP1.
//    - Exactly 2 re pulses per BD, never both re_tx and re_rx high together.
//    - Minimum BD turnaround: 6 cycles plus engine time.
//    - xfer_sys_addr, xfer_blk_addr and xfer_dir stay stable from LAUNCH until the next CAP0.
//  Boundary cases:
//    - xfer_done outside BUSY: ignored.
//    - Errored BD: still retired (a_cmp issued); no retry.
//    - en low mid-BD: the current BD completes, then the FSM stays in IDLE.
//    - clr_err together with a new error: set wins.
//    - free_bd >= BD_PAIRS: treated as empty; never underflows the read pointer.
// TESTING
//  - Single TX BD: free_bd_tx=7, dat_tx=0x1000 then 0x20. Expect:
//      re_tx two consecutive cycles; xfer_start with sys=0x1000, blk=0x20, dir=1;
//      xfer_done -> a_cmp_tx one cycle later, 1 cycle wide.
//  - Both pending (free_bd_tx=6, free_bd_rx=6): grants alternate TX,RX,TX,RX over 4 BDs.
//  - xfer_done with xfer_err=1 -> err=1 and a_cmp still pulses. clr_err -> err=0 next cycle.
//  - en=0 with BDs pending -> no re strobes. Drop en in BUSY -> current BD retires, then idle.
//  - rst_n low during BUSY -> all outputs 0 immediately, no a_cmp. After release, TX is granted first.
//  - free_bd_tx=8 (empty), free_bd_rx=8 for 100 cycles -> busy stays 0, no strobes.

Source files
------------

// File: rtl/sd_bd_sched.sv
// Round-robin TX/RX buffer-descriptor scheduler: fetches a 2-word BD from the
// granted buffer, launches one SD data transfer, and retires the BD on completion.
module sd_bd_sched #(
    parameter int RAM_MEM_WIDTH = 32,
    parameter int BD_WIDTH      = 8,
    parameter int BD_PAIRS      = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [BD_WIDTH-1:0]      free_bd_tx,
    input  logic [BD_WIDTH-1:0]      free_bd_rx,
    output logic                     re_tx,
    output logic                     re_rx,
    input  logic [RAM_MEM_WIDTH-1:0] dat_tx,
    input  logic [RAM_MEM_WIDTH-1:0] dat_rx,
    output logic                     a_cmp_tx,
    output logic                     a_cmp_rx,
    output logic                     xfer_start,
    output logic                     xfer_dir,
    output logic [RAM_MEM_WIDTH-1:0] xfer_sys_addr,
    output logic [RAM_MEM_WIDTH-1:0] xfer_blk_addr,
    input  logic                     xfer_done,
    input  logic                     xfer_err,
    output logic                     busy,
    output logic                     err,
    input  logic                     clr_err
);

    // state  | meaning
    // IDLE   | arbitrate between pending buffers
    // RD0    | first BD read strobe
    // CAP0   | capture word 0 (system address), second read strobe
    // CAP1   | capture word 1 (block address)
    // LAUNCH | xfer_start pulse to the data engine
    // BUSY   | wait for engine completion
    // CMPL   | a_cmp retire pulse
    // HOLD   | dead cycle so free_bd settles before re-arbitration
    typedef enum logic [2:0] {
        S_IDLE, S_RD0, S_CAP0, S_CAP1, S_LAUNCH, S_BUSY, S_CMPL, S_HOLD
    } state_t;

    localparam logic [BD_WIDTH-1:0] PAIRS = BD_WIDTH'(BD_PAIRS);

    state_t state;
    logic   gnt_tx;
    logic   last_tx;
    logic   pend_tx, pend_rx, grant_tx;

    assign pend_tx  = (free_bd_tx < PAIRS);
    assign pend_rx  = (free_bd_rx < PAIRS);
    // TX wins when it is the only requester or when RX was served last
    assign grant_tx = pend_tx && (!pend_rx || !last_tx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            gnt_tx        <= 1'b0;
            last_tx       <= 1'b0;
            re_tx         <= 1'b0;
            re_rx         <= 1'b0;
            a_cmp_tx      <= 1'b0;
            a_cmp_rx      <= 1'b0;
            xfer_start    <= 1'b0;
            xfer_dir      <= 1'b0;
            xfer_sys_addr <= '0;
            xfer_blk_addr <= '0;
            busy          <= 1'b0;
            err           <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (en && (pend_tx || pend_rx)) begin
                        gnt_tx  <= grant_tx;
                        last_tx <= grant_tx;
                        re_tx   <= grant_tx;
                        re_rx   <= !grant_tx;
                        busy    <= 1'b1;
                        state   <= S_RD0;
                    end
                end
                S_RD0: state <= S_CAP0;
                S_CAP0: begin
                    xfer_sys_addr <= gnt_tx ? dat_tx : dat_rx;
                    re_tx         <= 1'b0;
                    re_rx         <= 1'b0;
                    state         <= S_CAP1;
                end
                S_CAP1: begin
                    xfer_blk_addr <= gnt_tx ? dat_tx : dat_rx;
                    xfer_start    <= 1'b1;
                    xfer_dir      <= gnt_tx;
                    state         <= S_LAUNCH;
                end
                S_LAUNCH: begin
                    xfer_start <= 1'b0;
                    state      <= S_BUSY;
                end
                S_BUSY: begin
                    if (xfer_done) begin
                        a_cmp_tx <= gnt_tx;
                        a_cmp_rx <= !gnt_tx;
                        state    <= S_CMPL;
                    end
                end
                S_CMPL: begin
                    a_cmp_tx <= 1'b0;
                    a_cmp_rx <= 1'b0;
                    state    <= S_HOLD;
                end
                S_HOLD: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase

            // a new error outranks a simultaneous clear
            if (state == S_BUSY && xfer_done && xfer_err)
                err <= 1'b1;
            else if (clr_err)
                err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sd_bd_sched.sv
// Directed bench for sd_bd_sched with a small BD-buffer read model and engine responder.
module tb_sd_bd_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en = 1'b0;
    logic [7:0]  free_bd_tx = 8'd8;
    logic [7:0]  free_bd_rx = 8'd8;
    logic        re_tx, re_rx;
    logic [31:0] dat_tx, dat_rx;
    logic        a_cmp_tx, a_cmp_rx;
    logic        xfer_start, xfer_dir;
    logic [31:0] xfer_sys_addr, xfer_blk_addr;
    logic        xfer_done = 1'b0;
    logic        xfer_err = 1'b0;
    logic        busy, err;
    logic        clr_err = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] tx_mem [4];
    logic [31:0] rx_mem [4];
    logic [1:0]  tx_ptr, rx_ptr;

    always #5 clk = ~clk;

    sd_bd_sched #(.RAM_MEM_WIDTH(32), .BD_WIDTH(8), .BD_PAIRS(8)) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .free_bd_tx(free_bd_tx), .free_bd_rx(free_bd_rx),
        .re_tx(re_tx), .re_rx(re_rx), .dat_tx(dat_tx), .dat_rx(dat_rx),
        .a_cmp_tx(a_cmp_tx), .a_cmp_rx(a_cmp_rx),
        .xfer_start(xfer_start), .xfer_dir(xfer_dir),
        .xfer_sys_addr(xfer_sys_addr), .xfer_blk_addr(xfer_blk_addr),
        .xfer_done(xfer_done), .xfer_err(xfer_err),
        .busy(busy), .err(err), .clr_err(clr_err)
    );

    // BD buffer read ports: one-cycle latency, pointer advances per strobe
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_ptr <= 2'd0;
            rx_ptr <= 2'd0;
            dat_tx <= 32'd0;
            dat_rx <= 32'd0;
        end else begin
            if (re_tx) begin
                dat_tx <= tx_mem[tx_ptr];
                tx_ptr <= tx_ptr + 2'd1;
            end
            if (re_rx) begin
                dat_rx <= rx_mem[rx_ptr];
                rx_ptr <= rx_ptr + 2'd1;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_bd(input bit dir, input logic [31:0] sys, input logic [31:0] blk,
                          input bit e, input bit clr, input bit drop);
        int rt = 0;
        int rr = 0;
        int both = 0;
        bit seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (re_tx && re_rx) both++;
            rt += int'(re_tx);
            rr += int'(re_rx);
            if (xfer_start) seen = 1;
        end
        if (!seen) begin
            check("start_timeout", 64'd0, 64'd1);
            return;
        end
        if (drop) en = 1'b0;
        check("re_overlap", 64'(both), 64'd0);
        check("re_tx_cnt", 64'(rt), dir ? 64'd2 : 64'd0);
        check("re_rx_cnt", 64'(rr), dir ? 64'd0 : 64'd2);
        check("dir", 64'(xfer_dir), 64'(dir));
        check("sys", 64'(xfer_sys_addr), 64'(sys));
        check("blk", 64'(xfer_blk_addr), 64'(blk));
        @(negedge clk);
        @(negedge clk);
        check("a_cmp_early", 64'({a_cmp_tx, a_cmp_rx}), 64'd0);
        xfer_done = 1'b1; xfer_err = e; clr_err = clr;
        @(negedge clk);
        xfer_done = 1'b0; xfer_err = 1'b0; clr_err = 1'b0;
        check("a_cmp", 64'({a_cmp_tx, a_cmp_rx}), dir ? 64'd2 : 64'd1);
        check("sys_stable", 64'(xfer_sys_addr), 64'(sys));
        @(negedge clk);
        check("a_cmp_width", 64'({a_cmp_tx, a_cmp_rx}), 64'd0);
        check("busy_hold", 64'(busy), 64'd1);
        @(negedge clk);
        check("busy_idle", 64'(busy), 64'd0);
    endtask

    initial begin
        int cnt;
        bit seen;
        tx_mem[0] = 32'h0000_1000; tx_mem[1] = 32'h0000_0020;
        tx_mem[2] = 32'h0000_3000; tx_mem[3] = 32'h0000_0044;
        rx_mem[0] = 32'h0000_A000; rx_mem[1] = 32'h0000_0055;
        rx_mem[2] = 32'h0000_B000; rx_mem[3] = 32'h0000_0066;

        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ctl", 64'({re_tx, re_rx, a_cmp_tx, a_cmp_rx, xfer_start, xfer_dir, busy, err}), 64'd0);
        check("rst_addr", {xfer_sys_addr, xfer_blk_addr}, 64'd0);
        rst_n = 1'b1;

        // en low with both pending; stray xfer_done outside BUSY
        free_bd_tx = 8'd6; free_bd_rx = 8'd6;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            xfer_done = (i == 5);
            cnt += int'(re_tx) + int'(re_rx) + int'(busy) + int'(a_cmp_tx) + int'(a_cmp_rx);
        end
        xfer_done = 1'b0;
        check("en_low_quiet", 64'(cnt), 64'd0);

        // single TX BD
        free_bd_tx = 8'd7; free_bd_rx = 8'd8; en = 1'b1;
        run_bd(1'b1, 32'h1000, 32'h20, 1'b0, 1'b0, 1'b1);
        check("err_clean", 64'(err), 64'd0);

        // errored RX BD, clear asserted alongside the error
        free_bd_tx = 8'd8; free_bd_rx = 8'd7; en = 1'b1;
        run_bd(1'b0, 32'hA000, 32'h55, 1'b1, 1'b1, 1'b1);
        check("err_set", 64'(err), 64'd1);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check("err_clr", 64'(err), 64'd0);

        // reset during BUSY
        free_bd_tx = 8'd7; free_bd_rx = 8'd8; en = 1'b1;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (xfer_start) seen = 1;
        end
        check("rst_busy_start", 64'(seen), 64'd1);
        @(negedge clk);
        rst_n = 1'b0;
        en = 1'b0;
        #1;
        check("rst_busy_ctl", 64'({re_tx, re_rx, a_cmp_tx, a_cmp_rx, xfer_start, xfer_dir, busy, err}), 64'd0);
        check("rst_busy_addr", {xfer_sys_addr, xfer_blk_addr}, 64'd0);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            xfer_done = (i == 1);
            if (i == 3) rst_n = 1'b1;
            cnt += int'(a_cmp_tx) + int'(a_cmp_rx) + int'(busy);
        end
        xfer_done = 1'b0;
        check("rst_no_acmp", 64'(cnt), 64'd0);

        // both pending: TX first after reset, then alternation
        free_bd_tx = 8'd6; free_bd_rx = 8'd6; en = 1'b1;
        run_bd(1'b1, 32'h1000, 32'h20, 1'b0, 1'b0, 1'b0);
        run_bd(1'b0, 32'hA000, 32'h55, 1'b0, 1'b0, 1'b0);
        run_bd(1'b1, 32'h3000, 32'h44, 1'b0, 1'b0, 1'b0);
        run_bd(1'b0, 32'hB000, 32'h66, 1'b0, 1'b0, 1'b1);
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            cnt += int'(busy) + int'(re_tx) + int'(re_rx);
        end
        check("en_drop_idle", 64'(cnt), 64'd0);

        // empty and over-range free counts
        en = 1'b1; free_bd_tx = 8'd8; free_bd_rx = 8'd8;
        cnt = 0;
        repeat (100) begin
            @(negedge clk);
            cnt += int'(busy) + int'(re_tx) + int'(re_rx);
        end
        check("empty_idle", 64'(cnt), 64'd0);
        free_bd_tx = 8'd9; free_bd_rx = 8'hFF;
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            cnt += int'(busy) + int'(re_tx) + int'(re_rx);
        end
        check("overrange_idle", 64'(cnt), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
